bu_twiddle_mul: RTL and testbench
=================================

# bu_twiddle_mul

Front multiply stage of the NTT butterfly unit; it sits directly upstream of the Montgomery reduction stage. Per NTT layer it accepts a stream of 128 coefficient pairs (a, b). For each pair it generates the matching zeta (twiddle) index from an internal butterfly counter, reads the zeta, and forms the signed 32-bit product b·zeta. It emits that product together with the delay-aligned a coefficient, ready for the reducer.

## Interface
- `N_BF`, 128: butterflies per layer.
- `CW`, 16: coefficient and zeta width (signed).
- `PW`, 32: product width (signed).
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-low.
- `start` in 1: one-cycle pulse that begins a layer; honoured only when `busy`=0.
- `layer` in 3: NTT layer, 0..6, sampled on `start`.
- `busy` out 1: layer in progress (accepting inputs).
- `in_valid` in 1: input pair valid.
- `in_ready` out 1: stage can accept a pair.
- `in_a` in CW: butterfly top coefficient, passed through.
- `in_b` in CW: butterfly bottom coefficient, multiplied.
- `out_valid` out 1: output valid.
- `out_ready` in 1: downstream can accept.
- `out_a` out CW: `in_a` aligned to the product.
- `out_prod` out PW: signed product b·zeta[k].
- `out_last` out 1: marks the 128th output of a layer.

## Operation
- Start:
  - `start`=1 while idle with `layer`≤6 latches `layer`, clears butterfly counter `j`, and sets `busy`.
  - `start` while `busy`=1 is ignored.
  - `start` with `layer`>6 is ignored; `busy` stays 0.
- Zeta index for pair j (0..127):
  - len = 128>>layer.
  - group = j>>(7−layer).
  - k = (1<<layer) + group, range 1..127.
  - zeta[] is the standard Kyber signed Montgomery-domain table: zeta[1]=−758, zeta[2]=−359, zeta[3]=−1517.
- Handshake:
  - A pair is accepted on `in_valid && in_ready`.
  - `in_ready` = `busy` && !stall.
  - Stall = stage-2 register holds valid data && !`out_ready`.
- Counter: `j` increments per accepted pair. On the acceptance with j=127, `busy` clears and `j` wraps to 0.
- Pipeline:
  - Stage 1 registers a, b, the last flag and the zeta ROM read for index k.
  - Stage 2 registers the full signed product b·zeta, with a and the last flag.
  - Stall freezes both stages; no data is dropped or duplicated.
  - Bubbles (no `in_valid`) advance as invalid slots.
- Arithmetic:
  - Signed CW×CW multiply, sign-extended to PW.
  - |b|<2^15 and |zeta|<q, so the result never overflows.
- Layer overlap: a new `start` may arrive while the last pairs are still draining. Stage contents are unaffected by the new layer.
- Reset (`rst`=0, any time, including mid-layer):
  - `busy`, `in_ready`, `out_valid`, `out_last` go to 0.
  - `out_a` and `out_prod` go to 0.
  - `j` and the latched layer go to 0.
  - All in-flight data is discarded.

## Timing
- Latency: 2 cycles from accepting edge to `out_valid` with no stall. Throughput is 1 pair/cycle.
- `busy` rises the cycle after `start` and falls the cycle after the 128th acceptance.
- `in_ready` is combinational from `out_ready` through the stall term. No combinational path exists from `in_valid` to any output.
- `out_last` asserts together with `out_valid` for pair 127 and holds while stalled.
- Outputs remain stable while `out_valid && !out_ready`.

## Structure
- Shared package `ntt_pkg`:
  - `KYBER_Q`=3329, `N_BF`, `CW`, `PW`, `ZETA_W`.
  - typedefs `coef_t` (signed CW) and `prod_t` (signed PW).
  - the 128-entry zeta constant array.
- Sub-module `zeta_rom`: 7-bit address, registered signed CW data, 1-cycle read, enable tied to !stall.
- Top module holds the control counter/FSM (IDLE, RUN) and the two pipeline registers.

## Test plan
- Layer 0, 128 pairs with b=1, a=j, `out_ready`=1:
  - Every `out_prod`=0xFFFFFD0A (−758) and `out_a`=j, first output 2 cycles after first accept.
  - `out_last` only on the 128th output; `busy` low afterward.
- Layer 1, b=2:
  - Pairs 0..63 give −718 (0xFFFFFD32).
  - Pairs 64..127 give −3034 (0xFFFFF426).
- Layer 6, b=−1: pair j gives −zeta[64+(j>>1)]. Check pairs 0/1 share zeta[64] and pair 127 uses zeta[127].
- Random `out_ready` backpressure (50%) and random `in_valid` gaps on layer 3:
  - Output sequence matches the reference model exactly: no loss, no duplicates.
  - Outputs stay stable during stall.
- `start` pulses mid-layer and with `layer`=7:
  - Ignored; counter and `busy` unaffected.
  - Exactly 128 acceptances per valid start.
- Assert `rst` low at pair 40 of layer 2:
  - `out_valid`, `busy` and `in_ready` are 0 immediately (asynchronously).
  - After release, a new layer-2 start produces pair 0 with zeta[4].

Source files
------------

// File: rtl/ntt_pkg.sv
// Shared NTT datapath types, widths and the Kyber twiddle table used by the
// butterfly front multiply stage.
package ntt_pkg;

    localparam int KYBER_Q = 3329;
    localparam int N_BF    = 128;
    localparam int CW      = 16;
    localparam int PW      = 32;
    localparam int ZETA_W  = CW;

    typedef logic signed [CW-1:0] coef_t;
    typedef logic signed [PW-1:0] prod_t;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    // Kyber zetas in signed Montgomery form, bit-reversed order.
    localparam int ZETAS [N_BF] = '{
        -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
         -171,   622,  1577,   182,   962, -1202, -1474,  1468,
          573, -1325,   264,   383,  -829,  1458, -1602,  -130,
         -681,  1017,   732,   608, -1542,   411,  -205, -1571,
         1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
          516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
         -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
         -398,   961, -1508,  -725,   448, -1065,   677, -1275,
        -1103,   430,   555,   843, -1251,   871,  1550,   105,
          422,   587,   177,  -235,  -291,  -460,  1574,  1653,
         -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
        -1590,   644,  -872,   349,   418,   329,  -156,   -75,
          817,  1097,   603,   610,  1322, -1285, -1465,   384,
        -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
        -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
         -108,  -308,   996,   991,   958, -1460,  1522,  1628
    };

    // Each layer has 2^layer groups; group g of that layer uses zeta[2^layer + g].
    function automatic logic [6:0] zeta_index(input logic [2:0] layer, input logic [6:0] j);
        logic [6:0] base;
        logic [6:0] group;
        base  = 7'(1) << layer;
        group = j >> (3'd7 - layer);
        return base + group;
    endfunction

endpackage

// File: rtl/zeta_rom.sv
// Registered twiddle ROM: one-cycle read, output held when the enable is low.
module zeta_rom
    import ntt_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [6:0]  addr,
    output coef_t       data
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data <= '0;
        end else if (en) begin
            data <= coef_t'(ZETAS[addr]);
        end
    end

endmodule

// File: rtl/bu_twiddle_mul.sv
// NTT butterfly front stage: generates the twiddle index per pair and forms
// b*zeta through a two-stage stallable pipeline, with a carried alongside.
module bu_twiddle_mul
    import ntt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [2:0]           layer,
    output logic                 busy,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [CW-1:0] in_a,
    input  logic signed [CW-1:0] in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [CW-1:0] out_a,
    output logic signed [PW-1:0] out_prod,
    output logic                 out_last
);

    state_t     state;
    logic [6:0] j;
    logic [2:0] layer_q;

    logic       stall;
    logic       accept;

    logic       s1_valid;
    coef_t      s1_a;
    coef_t      s1_b;
    logic       s1_last;
    coef_t      zeta;

    logic       s2_valid;
    coef_t      s2_a;
    prod_t      s2_prod;
    logic       s2_last;

    // A full stage-2 register blocked downstream freezes the whole pipe.
    assign stall    = s2_valid && !out_ready;
    assign busy     = (state == RUN);
    assign in_ready = busy && !stall;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            j       <= '0;
            layer_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (layer <= 3'd6)) begin
                        layer_q <= layer;
                        j       <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (accept) begin
                        j <= j + 7'd1;
                        if (j == 7'd127) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    zeta_rom u_zeta_rom (
        .clk  (clk),
        .rst  (rst),
        .en   (!stall),
        .addr (zeta_index(layer_q, j)),
        .data (zeta)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_last  <= 1'b0;
        end else if (!stall) begin
            s1_valid <= accept;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_last  <= accept && (j == 7'd127);
        end
    end

    // Operands are sign-extended first so the full 32-bit product is kept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_a     <= '0;
            s2_prod  <= '0;
            s2_last  <= 1'b0;
        end else if (!stall) begin
            s2_valid <= s1_valid;
            s2_a     <= s1_a;
            s2_prod  <= prod_t'(s1_b) * prod_t'(zeta);
            s2_last  <= s1_valid && s1_last;
        end
    end

    assign out_valid = s2_valid;
    assign out_a     = s2_a;
    assign out_prod  = s2_prod;
    assign out_last  = s2_last;

endmodule

// File: tb/tb_bu_twiddle_mul.sv
// Scoreboard bench for bu_twiddle_mul: driver pushes expected results on each
// accepted pair, an independent monitor pops and compares on each output.
module tb_bu_twiddle_mul;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [2:0]         layer;
    logic               busy;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_a;
    logic signed [15:0] in_b;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic signed [15:0] out_a;
    logic signed [31:0] out_prod;
    logic               out_last;

    typedef struct {
        logic signed [15:0] a;
        logic signed [31:0] prod;
        logic               last;
    } exp_t;

    exp_t sbq[$];
    exp_t held;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   first_acc = -1;
    int   first_out = -1;
    int   nacc;
    logic bp_en = 1'b0;
    logic stalled_prev = 1'b0;

    localparam int ZT [128] = '{
        -1044,  -758,  -359, -1517,  1493,  1422,   287,   202,
         -171,   622,  1577,   182,   962, -1202, -1474,  1468,
          573, -1325,   264,   383,  -829,  1458, -1602,  -130,
         -681,  1017,   732,   608, -1542,   411,  -205, -1571,
         1223,   652,  -552,  1015, -1293,  1491,  -282, -1544,
          516,    -8,  -320,  -666, -1618, -1162,   126,  1469,
         -853,   -90,  -271,   830,   107, -1421,  -247,  -951,
         -398,   961, -1508,  -725,   448, -1065,   677, -1275,
        -1103,   430,   555,   843, -1251,   871,  1550,   105,
          422,   587,   177,  -235,  -291,  -460,  1574,  1653,
         -246,   778,  1159,  -147,  -777,  1483,  -602,  1119,
        -1590,   644,  -872,   349,   418,   329,  -156,   -75,
          817,  1097,   603,   610,  1322, -1285, -1465,   384,
        -1215,  -136,  1218, -1335,  -874,   220, -1187, -1659,
        -1185, -1530, -1278,   794, -1510,  -854,  -870,   478,
         -108,  -308,   996,   991,   958, -1460,  1522,  1628
    };

    bu_twiddle_mul dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .layer     (layer),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_prod  (out_prod),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check_eq(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Hand-computed constants where the test plan names them, table lookup otherwise.
    function automatic logic signed [31:0] exp_prod(input logic [2:0] l, input int j,
                                                    input logic signed [15:0] b);
        int k;
        if (l == 3'd0) return -32'sd758;
        if (l == 3'd1) return (j < 64) ? -32'sd718 : -32'sd3034;
        if (l == 3'd6 && j < 2) return 32'sd1103;
        if (l == 3'd6 && j == 127) return -32'sd1628;
        if (l == 3'd2 && j == 0) return 32'sd1493;
        k = (1 << l) + (j >> (7 - l));
        return 32'(int'(b) * ZT[k]);
    endfunction

    task automatic pulse_start(input logic [2:0] l);
        start = 1'b1;
        layer = l;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // mode 1 adds random in_valid gaps and an ignored mid-layer start.
    task automatic applyStimulus(input logic [2:0] l, input int mode, input int rst_at,
                                 output int n);
        int guard;
        logic signed [15:0] b;
        exp_t e;
        n = 0;
        guard = 0;
        pulse_start(l);
        check_eq("busy_after_start", busy, 1);
        while (n < 128 && guard < 4000) begin
            case (l)
                3'd0, 3'd2: b = 16'sd1;
                3'd1:       b = 16'sd2;
                3'd6:       b = -16'sd1;
                default:    b = 16'($urandom);
            endcase
            in_a     = 16'(n + 1000 * int'(l));
            in_b     = b;
            in_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (mode == 1 && guard == 60) begin
                start = 1'b1;
                layer = 3'd1;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                e.a    = in_a;
                e.prod = exp_prod(l, n, b);
                e.last = (n == 127);
                sbq.push_back(e);
                if (first_acc < 0) first_acc = cyc;
                n++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            layer = l;
            guard++;
            if (n == rst_at) break;
        end
        in_valid = 1'b0;
        if (rst_at < 0) begin
            check_eq("busy_after_last", busy, 0);
            check_eq("in_ready_after_last", in_ready, 0);
        end
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (sbq.size() != 0 && g < 400) begin
            @(posedge clk);
            g++;
        end
        #1;
        check_eq("drain_queue", sbq.size(), 0);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard pops on every handshake, plus hold check after a stall.
    initial begin : checkOutput
        exp_t e;
        forever begin
            @(negedge clk);
            if (stalled_prev) begin
                check_eq("stall_hold_valid", out_valid, 1);
                check_eq("stall_hold_a", out_a, held.a);
                check_eq("stall_hold_prod", out_prod, held.prod);
                check_eq("stall_hold_last", out_last, held.last);
            end
            if (out_valid && first_out < 0) first_out = cyc;
            if (out_valid && out_ready) begin
                check_eq("sb_nonempty", sbq.size() > 0, 1);
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check_eq("out_a", out_a, e.a);
                    check_eq("out_prod", out_prod, e.prod);
                    check_eq("out_last", out_last, e.last);
                end
            end
            stalled_prev = rst && out_valid && !out_ready;
            held.a    = out_a;
            held.prod = out_prod;
            held.last = out_last;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0; start = 1'b0; layer = 3'd0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_in_ready", in_ready, 0);
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_last", out_last, 0);
        check_eq("reset_out_prod", out_prod, 0);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(3'd0, 0, -1, nacc);
        check_eq("layer0_accepts", nacc, 128);
        applyStimulus(3'd1, 0, -1, nacc);
        check_eq("layer1_accepts", nacc, 128);
        wait_drain();
        check_eq("first_latency", first_out - first_acc, 2);

        applyStimulus(3'd6, 0, -1, nacc);
        check_eq("layer6_accepts", nacc, 128);
        wait_drain();

        bp_en = 1'b1;
        applyStimulus(3'd3, 1, -1, nacc);
        check_eq("layer3_accepts", nacc, 128);
        wait_drain();
        bp_en = 1'b0;
        @(posedge clk);
        #1;

        pulse_start(3'd7);
        check_eq("layer7_busy", busy, 0);
        check_eq("layer7_in_ready", in_ready, 0);
        @(posedge clk);
        #1;

        applyStimulus(3'd2, 0, 40, nacc);
        check_eq("layer2_pre_reset_accepts", nacc, 40);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_out_valid", out_valid, 0);
        check_eq("async_rst_busy", busy, 0);
        check_eq("async_rst_in_ready", in_ready, 0);
        check_eq("async_rst_out_prod", out_prod, 0);
        sbq.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(3'd2, 0, -1, nacc);
        check_eq("layer2_accepts", nacc, 128);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
